// File: rtl/cache_line_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_xfer_pkg
// Description : Shared widths, state encoding and address helper for the
//               cache line-transfer engine.
//               Contents: ADDR_W/DATA_W bus widths, TAG_W/IDX_W address
//               fields, WORDS/WORD_W line geometry, MEM_LAT_DEF read latency,
//               xfer_state_t state enum, line_addr() word-address builder.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_line_xfer_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int TAG_W       = 5;
    localparam int IDX_W       = 8;
    localparam int WORDS       = 4;
    localparam int WORD_W      = 2;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WB         = 3'd1,
        ST_FILL_ISSUE = 3'd2,
        ST_FILL_DRAIN = 3'd3,
        ST_DONE       = 3'd4
    } xfer_state_t;

    // Byte address of word w of the line {tag, index}; words are 16-bit so
    // bit 0 is always zero.
    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [IDX_W-1:0]  idx,
        input logic [WORD_W-1:0] w
    );
        return {tag, idx, w, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module      : dff
// Description : Enabled register with synchronous active-low clear to zero.
// Ports       : clk  - clock
//               rst  - synchronous reset, low = clear
//               i_en - load enable
//               i_d  - next value
//               o_q  - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/xfer_ret_pipe.sv
`default_nettype none
// ============================================================================
// Module      : xfer_ret_pipe
// Description : DEPTH-stage shift register tracking outstanding memory reads.
//               Each stage holds {valid, word index}; the last stage lines up
//               with the cycle the memory presents the read data.
// Ports       : clk     - clock
//               rst     - synchronous clear, low = empty pipe
//               i_push  - a read is issued this cycle
//               i_word  - word index of the issued read
//               o_valid - read data for o_word is on the memory bus
//               o_word  - word index of the returning read
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_ret_pipe
    import cache_line_xfer_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {i_push, i_word};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1][WORD_W];
    assign o_word  = r_stage[DEPTH-1][WORD_W-1:0];

endmodule
`default_nettype wire

// File: rtl/cache_line_xfer.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_xfer
// Description : Line-transfer engine between the direct-mapped cache and the
//               four-bank main memory. Optionally writes back a dirty victim
//               line, then optionally refills the line, honouring per-bank
//               busy, and pulses o_done once the line is resident.
// Ports       : clk, rst (sync, active low)
//               i_start/i_evict/i_fill/i_miss_addr/i_victim_tag - request
//               i_cache_data_out - cache read data (same cycle)
//               i_mem_data_out   - memory read data (MEM_LAT after mem_rd)
//               i_busy           - per-bank busy, bank = addr[2:1]
//               o_cache_*        - cache word port
//               o_mem_*          - memory word port
//               o_xfer_busy      - engine owns the ports
//               o_done           - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_xfer
    import cache_line_xfer_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_evict,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic [TAG_W-1:0]  i_victim_tag,
    input  logic [DATA_W-1:0] i_cache_data_out,
    input  logic [DATA_W-1:0] i_mem_data_out,
    input  logic [3:0]        i_busy,
    output logic              o_cache_en,
    output logic              o_cache_wr,
    output logic              o_cache_valid_in,
    output logic [IDX_W-1:0]  o_cache_index,
    output logic [TAG_W-1:0]  o_cache_tag,
    output logic [2:0]        o_cache_offset,
    output logic [DATA_W-1:0] o_cache_data_in,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_in,
    output logic              o_xfer_busy,
    output logic              o_done
);

    localparam logic [WORD_W-1:0] c_LAST_WORD = WORD_W'(WORDS - 1);
    localparam int                c_LAT_W     = 2 * TAG_W + IDX_W + 1;

    logic [2:0]         w_state_q;
    logic [2:0]         w_state_d;
    xfer_state_t        w_state;
    xfer_state_t        w_state_nxt;
    logic [WORD_W-1:0]  w_k_q;
    logic [WORD_W-1:0]  w_k_d;
    logic [WORD_W-1:0]  w_j_q;
    logic [WORD_W-1:0]  w_j_d;

    // Request latches: {fill, victim tag, miss tag, index}
    logic               w_lat_en;
    logic [c_LAT_W-1:0] w_lat_d;
    logic [c_LAT_W-1:0] w_lat_q;
    logic               w_fill_q;
    logic [TAG_W-1:0]   w_vtag_q;
    logic [TAG_W-1:0]   w_tag_q;
    logic [IDX_W-1:0]   w_idx_q;

    logic               w_push;
    logic               w_ret_valid;
    logic [WORD_W-1:0]  w_ret_word;
    logic               w_unused_bits;

    assign w_state   = xfer_state_t'(w_state_q);
    assign w_state_d = w_state_nxt;
    assign {w_fill_q, w_vtag_q, w_tag_q, w_idx_q} = w_lat_q;

    // Offset bits of the miss address and the travelling word index are not
    // needed: the line is always transferred whole and j tracks returns.
    assign w_unused_bits = ^{i_miss_addr[2:0], w_ret_word};

    dff #(.WIDTH(3)) u_state_ff (
        .clk (clk), .rst (rst), .i_en (1'b1), .i_d (w_state_d), .o_q (w_state_q)
    );

    dff #(.WIDTH(WORD_W)) u_k_ff (
        .clk (clk), .rst (rst), .i_en (1'b1), .i_d (w_k_d), .o_q (w_k_q)
    );

    dff #(.WIDTH(WORD_W)) u_j_ff (
        .clk (clk), .rst (rst), .i_en (1'b1), .i_d (w_j_d), .o_q (w_j_q)
    );

    dff #(.WIDTH(c_LAT_W)) u_lat_ff (
        .clk (clk), .rst (rst), .i_en (w_lat_en), .i_d (w_lat_d), .o_q (w_lat_q)
    );

    xfer_ret_pipe #(.DEPTH(MEM_LAT)) u_ret_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_word  (w_k_q),
        .o_valid (w_ret_valid),
        .o_word  (w_ret_word)
    );

    always_comb begin
        w_state_nxt      = w_state;
        w_k_d            = w_k_q;
        w_j_d            = w_j_q;
        w_lat_en         = 1'b0;
        w_lat_d          = '0;
        w_push           = 1'b0;
        o_cache_en       = 1'b0;
        o_cache_wr       = 1'b0;
        o_cache_valid_in = 1'b0;
        o_cache_index    = '0;
        o_cache_tag      = '0;
        o_cache_offset   = '0;
        o_cache_data_in  = '0;
        o_mem_rd         = 1'b0;
        o_mem_wr         = 1'b0;
        o_mem_addr       = '0;
        o_mem_data_in    = '0;
        o_xfer_busy      = (w_state != ST_IDLE);
        o_done           = 1'b0;

        if (w_state != ST_IDLE) begin
            o_cache_index = w_idx_q;
        end

        case (w_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_lat_en = 1'b1;
                    w_lat_d  = {i_fill, i_victim_tag, i_miss_addr[15:11],
                                i_miss_addr[10:3]};
                    if (i_evict) begin
                        w_state_nxt = ST_WB;
                    end else if (i_fill) begin
                        w_state_nxt = ST_FILL_ISSUE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_WB: begin
                // Cache read data goes straight onto the memory write bus;
                // the same word is re-read on every stalled cycle.
                o_cache_en     = 1'b1;
                o_cache_offset = {w_k_q, 1'b0};
                o_mem_addr     = line_addr(w_vtag_q, w_idx_q, w_k_q);
                o_mem_data_in  = i_cache_data_out;
                if (!i_busy[w_k_q]) begin
                    o_mem_wr = 1'b1;
                    w_k_d    = w_k_q + 1'b1;
                    if (w_k_q == c_LAST_WORD) begin
                        w_state_nxt = w_fill_q ? ST_FILL_ISSUE : ST_DONE;
                    end
                end
            end

            ST_FILL_ISSUE: begin
                o_mem_addr = line_addr(w_tag_q, w_idx_q, w_k_q);
                if (!i_busy[w_k_q]) begin
                    o_mem_rd = 1'b1;
                    w_push   = 1'b1;
                    w_k_d    = w_k_q + 1'b1;
                    if (w_k_q == c_LAST_WORD) begin
                        w_state_nxt = ST_FILL_DRAIN;
                    end
                end
            end

            ST_FILL_DRAIN: begin
                if (w_ret_valid && (w_j_q == c_LAST_WORD)) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                o_done      = 1'b1;
                w_lat_en    = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Returning read data is written into the cache the cycle it arrives;
        // this overlaps with issue of later words.
        if (((w_state == ST_FILL_ISSUE) || (w_state == ST_FILL_DRAIN)) && w_ret_valid) begin
            o_cache_en       = 1'b1;
            o_cache_wr       = 1'b1;
            o_cache_valid_in = 1'b1;
            o_cache_tag      = w_tag_q;
            o_cache_offset   = {w_j_q, 1'b0};
            o_cache_data_in  = i_mem_data_out;
            w_j_d            = w_j_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_xfer
// Description : Directed self-checking bench for cache_line_xfer. The memory
//               returns 0xA0+word two cycles after a read; the cache returns
//               0xB0+word for any read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_xfer;

    logic        clk;
    logic        rst;
    logic        i_start, i_evict, i_fill;
    logic [15:0] i_miss_addr;
    logic [4:0]  i_victim_tag;
    logic [15:0] i_cache_data_out, i_mem_data_out;
    logic [3:0]  i_busy;
    logic        o_cache_en, o_cache_wr, o_cache_valid_in;
    logic [7:0]  o_cache_index;
    logic [4:0]  o_cache_tag;
    logic [2:0]  o_cache_offset;
    logic [15:0] o_cache_data_in;
    logic        o_mem_rd, o_mem_wr;
    logic [15:0] o_mem_addr, o_mem_data_in;
    logic        o_xfer_busy, o_done;

    int n_cmp = 0;
    int n_err = 0;

    cache_line_xfer dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_evict          (i_evict),
        .i_fill           (i_fill),
        .i_miss_addr      (i_miss_addr),
        .i_victim_tag     (i_victim_tag),
        .i_cache_data_out (i_cache_data_out),
        .i_mem_data_out   (i_mem_data_out),
        .i_busy           (i_busy),
        .o_cache_en       (o_cache_en),
        .o_cache_wr       (o_cache_wr),
        .o_cache_valid_in (o_cache_valid_in),
        .o_cache_index    (o_cache_index),
        .o_cache_tag      (o_cache_tag),
        .o_cache_offset   (o_cache_offset),
        .o_cache_data_in  (o_cache_data_in),
        .o_mem_rd         (o_mem_rd),
        .o_mem_wr         (o_mem_wr),
        .o_mem_addr       (o_mem_addr),
        .o_mem_data_in    (o_mem_data_in),
        .o_xfer_busy      (o_xfer_busy),
        .o_done           (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed two-cycle read latency.
    logic [1:0]  r_rd_v;
    logic [15:0] r_rd_a0, r_rd_a1;
    initial begin
        r_rd_v  = '0;
        r_rd_a0 = '0;
        r_rd_a1 = '0;
    end
    always @(posedge clk) begin
        r_rd_v  <= {r_rd_v[0], o_mem_rd};
        r_rd_a0 <= o_mem_addr;
        r_rd_a1 <= r_rd_a0;
    end
    assign i_mem_data_out   = r_rd_v[1] ? (16'h00A0 + {14'b0, r_rd_a1[2:1]}) : 16'h0000;
    assign i_cache_data_out = 16'h00B0 + {14'b0, o_cache_offset[2:1]};

    // Observations of one run
    int          wr_cyc [4];
    logic [2:0]  wr_off [4];
    logic [15:0] wr_dat [4];
    logic [4:0]  wr_tag;
    logic [7:0]  wr_idx;
    int          mw_cyc [4];
    logic [15:0] mw_addr [4];
    logic [15:0] mw_dat [4];
    int n_cwr, n_mwr, n_rd, n_cen, n_done, done_cyc, n_both, n_bad_vin;
    int n_rd_busy, n_after_rst;
    logic post_rst_quiet;

    task automatic run_xfer(input logic ev, input logic fl, input logic [15:0] addr,
                            input logic [4:0] vt, input int bbank, input int bfrom,
                            input int blen, input int restart_cyc, input int rst_cyc,
                            input int ncyc);
        n_cwr = 0; n_mwr = 0; n_rd = 0; n_cen = 0; n_done = 0; done_cyc = -1;
        n_both = 0; n_bad_vin = 0; n_rd_busy = 0; n_after_rst = 0;
        post_rst_quiet = 1'b0; wr_tag = '0; wr_idx = '0;
        for (int i = 0; i < 4; i++) begin
            wr_cyc[i] = -1; wr_off[i] = '0; wr_dat[i] = '0;
            mw_cyc[i] = -1; mw_addr[i] = '0; mw_dat[i] = '0;
        end
        @(negedge clk);
        i_start = 1'b1; i_evict = ev; i_fill = fl;
        i_miss_addr = addr; i_victim_tag = vt; i_busy = 4'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            i_start = (n == restart_cyc);
            i_busy  = (n >= bfrom && n < bfrom + blen) ? (4'b0001 << bbank) : 4'b0000;
            rst     = (n == rst_cyc) ? 1'b0 : 1'b1;
            #1;
            if (n == rst_cyc + 1)
                post_rst_quiet = ({o_cache_en, o_cache_wr, o_cache_valid_in, o_cache_index,
                                   o_cache_tag, o_cache_offset, o_cache_data_in, o_mem_rd,
                                   o_mem_wr, o_mem_addr, o_mem_data_in, o_xfer_busy,
                                   o_done} == '0);
            if (rst_cyc > 0 && n > rst_cyc && n <= rst_cyc + 8 &&
                (o_xfer_busy || o_cache_en || o_mem_rd || o_mem_wr))
                n_after_rst++;
            if (o_cache_en) n_cen++;
            if (o_cache_en && o_cache_wr) begin
                if (n_cwr < 4) begin
                    wr_cyc[n_cwr] = n; wr_off[n_cwr] = o_cache_offset;
                    wr_dat[n_cwr] = o_cache_data_in;
                end
                wr_tag = o_cache_tag; wr_idx = o_cache_index;
                if (!o_cache_valid_in) n_bad_vin++;
                n_cwr++;
            end
            if (o_mem_wr) begin
                if (n_mwr < 4) begin
                    mw_cyc[n_mwr] = n; mw_addr[n_mwr] = o_mem_addr;
                    mw_dat[n_mwr] = o_mem_data_in;
                end
                n_mwr++;
            end
            if (o_mem_rd) begin
                n_rd++;
                if (i_busy[o_mem_addr[2:1]]) n_rd_busy++;
            end
            if (o_mem_rd && o_mem_wr) n_both++;
            if (o_done) begin
                n_done++;
                done_cyc = n;
            end
        end
        i_start = 1'b0; i_busy = 4'b0; rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if ({o_cache_en, o_cache_wr, o_mem_rd, o_mem_wr, o_mem_addr, o_cache_index} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b wr=%b rd=%b mwr=%b addr=%h idx=%h want all 0",
                     o_cache_en, o_cache_wr, o_mem_rd, o_mem_wr, o_mem_addr, o_cache_index);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({o_xfer_busy, o_done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", o_xfer_busy, o_done);
        end
    endtask

    task automatic test_fill_only();
        run_xfer(1'b0, 1'b1, 16'h1238, 5'h00, 0, 0, 0, 0, 0, 12);
        n_cmp++;
        if (n_cwr !== 4) begin n_err++; $display("FAIL fill_count: got %0d want 4", n_cwr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wr_off[i] !== 3'(2 * i) || wr_dat[i] !== 16'(16'h00A0 + i) || wr_cyc[i] !== 3 + i) begin
                n_err++;
                $display("FAIL fill_word%0d: got off=%0d data=%h cyc=%0d want off=%0d data=%h cyc=%0d",
                         i, wr_off[i], wr_dat[i], wr_cyc[i], 2 * i, 16'h00A0 + i, 3 + i);
            end
        end
        n_cmp++;
        if (wr_tag !== 5'h02 || wr_idx !== 8'h47 || n_bad_vin !== 0) begin
            n_err++;
            $display("FAIL fill_tag_idx: got tag=%h idx=%h badvin=%0d want tag=02 idx=47 badvin=0",
                     wr_tag, wr_idx, n_bad_vin);
        end
        n_cmp++;
        if (done_cyc !== 7 || n_done !== 1 || n_mwr !== 0) begin
            n_err++;
            $display("FAIL fill_done: got done_cyc=%0d ndone=%0d nmwr=%0d want 7 1 0",
                     done_cyc, n_done, n_mwr);
        end
    endtask

    task automatic test_evict_fill();
        run_xfer(1'b1, 1'b1, 16'h1238, 5'h1F, 0, 0, 0, 0, 0, 16);
        n_cmp++;
        if (n_mwr !== 4) begin n_err++; $display("FAIL wb_count: got %0d want 4", n_mwr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mw_addr[i] !== 16'(16'hFA38 + 2 * i) || mw_dat[i] !== 16'(16'h00B0 + i) || mw_cyc[i] !== 1 + i) begin
                n_err++;
                $display("FAIL wb_word%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                         i, mw_addr[i], mw_dat[i], mw_cyc[i], 16'hFA38 + 2 * i, 16'h00B0 + i, 1 + i);
            end
        end
        n_cmp++;
        if (n_cwr !== 4 || wr_cyc[0] !== 7 || wr_cyc[3] !== 10 || wr_dat[3] !== 16'h00A3) begin
            n_err++;
            $display("FAIL ef_fill: got n=%0d first=%0d last=%0d d3=%h want 4 7 10 00a3",
                     n_cwr, wr_cyc[0], wr_cyc[3], wr_dat[3]);
        end
        n_cmp++;
        if (done_cyc !== 11 || n_done !== 1 || n_rd !== 4 || n_both !== 0) begin
            n_err++;
            $display("FAIL ef_done: got done_cyc=%0d ndone=%0d nrd=%0d both=%0d want 11 1 4 0",
                     done_cyc, n_done, n_rd, n_both);
        end
    endtask

    task automatic test_busy_stall();
        run_xfer(1'b0, 1'b1, 16'h1238, 5'h00, 2, 3, 3, 0, 0, 16);
        n_cmp++;
        if (n_rd !== 4 || n_rd_busy !== 0) begin
            n_err++;
            $display("FAIL stall_reads: got nrd=%0d rd_while_busy=%0d want 4 0", n_rd, n_rd_busy);
        end
        n_cmp++;
        if (n_cwr !== 4 || wr_off[2] !== 3'd4 || wr_dat[2] !== 16'h00A2 || wr_cyc[2] !== 8 || wr_cyc[3] !== 9) begin
            n_err++;
            $display("FAIL stall_writes: got n=%0d off2=%0d d2=%h c2=%0d c3=%0d want 4 4 00a2 8 9",
                     n_cwr, wr_off[2], wr_dat[2], wr_cyc[2], wr_cyc[3]);
        end
        n_cmp++;
        if (done_cyc !== 10 || n_done !== 1) begin
            n_err++;
            $display("FAIL stall_done: got cyc=%0d n=%0d want 10 1", done_cyc, n_done);
        end
    endtask

    task automatic test_restart_ignored();
        run_xfer(1'b1, 1'b1, 16'h1238, 5'h1F, 0, 0, 0, 3, 0, 20);
        n_cmp++;
        if (n_done !== 1 || done_cyc !== 11 || n_mwr !== 4 || n_cwr !== 4) begin
            n_err++;
            $display("FAIL restart: got ndone=%0d cyc=%0d nmwr=%0d ncwr=%0d want 1 11 4 4",
                     n_done, done_cyc, n_mwr, n_cwr);
        end
    endtask

    task automatic test_reset_mid();
        run_xfer(1'b1, 1'b1, 16'h1238, 5'h1F, 0, 0, 0, 0, 6, 16);
        n_cmp++;
        if (post_rst_quiet !== 1'b1 || n_done !== 0 || n_after_rst !== 0) begin
            n_err++;
            $display("FAIL reset_mid: got quiet=%b ndone=%0d active_after=%0d want 1 0 0",
                     post_rst_quiet, n_done, n_after_rst);
        end
        run_xfer(1'b0, 1'b1, 16'h1238, 5'h00, 0, 0, 0, 0, 0, 12);
        n_cmp++;
        if (done_cyc !== 7 || n_cwr !== 4 || wr_dat[0] !== 16'h00A0 || wr_off[0] !== 3'd0) begin
            n_err++;
            $display("FAIL reset_recover: got cyc=%0d ncwr=%0d d0=%h off0=%0d want 7 4 00a0 0",
                     done_cyc, n_cwr, wr_dat[0], wr_off[0]);
        end
    endtask

    task automatic test_neither();
        run_xfer(1'b0, 1'b0, 16'h5678, 5'h0A, 0, 0, 0, 0, 0, 6);
        n_cmp++;
        if (done_cyc !== 1 || n_done !== 1 || n_cen !== 0 || n_rd !== 0 || n_mwr !== 0) begin
            n_err++;
            $display("FAIL neither: got cyc=%0d ndone=%0d cen=%0d rd=%0d mwr=%0d want 1 1 0 0 0",
                     done_cyc, n_done, n_cen, n_rd, n_mwr);
        end
    endtask

    task automatic test_evict_only();
        run_xfer(1'b1, 1'b0, 16'h1238, 5'h1F, 0, 0, 0, 0, 0, 8);
        n_cmp++;
        if (done_cyc !== 5 || n_mwr !== 4 || n_rd !== 0 || n_cwr !== 0 || mw_addr[3] !== 16'hFA3E) begin
            n_err++;
            $display("FAIL evict_only: got cyc=%0d mwr=%0d rd=%0d cwr=%0d a3=%h want 5 4 0 0 fa3e",
                     done_cyc, n_mwr, n_rd, n_cwr, mw_addr[3]);
        end
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_evict = 1'b0; i_fill = 1'b0;
        i_miss_addr = '0; i_victim_tag = '0; i_busy = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fill_only();
        test_evict_fill();
        test_busy_stall();
        test_restart_ignored();
        test_reset_mid();
        test_neither();
        test_evict_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_xfer.md
# cache_line_xfer

Line-transfer engine between the direct-mapped cache controller and the four-bank main memory. On a miss the controller hands it one request: optionally write back the dirty victim line (4 words), then optionally refill the line from memory. The engine sequences the word-by-word cache reads/writes and bank accesses, honours per-bank `busy`, and pulses `done` when the line is resident. It owns the cache and memory ports only while `xfer_busy` is high.

## Interface
- `MEM_LAT`, 2, cycles from `mem_rd` issue to valid `mem_data_out`
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-low reset (sampled on rising `clk`, low = reset)
- `start`  in  1  request pulse; sampled only in IDLE
- `evict`  in  1  with `start`: write back victim first
- `fill`  in  1  with `start`: refill line from memory
- `miss_addr`  in  16  requesting address; tag = [15:11], index = [10:3]
- `victim_tag`  in  5  tag of dirty line being evicted
- `cache_data_out`  in  16  cache read data (combinational, same cycle)
- `mem_data_out`  in  16  memory read data
- `busy`  in  4  per-bank busy; bank = address[2:1]
- `cache_en`, `cache_wr`, `cache_valid_in`  out  1 each  cache controls (comp is always 0 from this block)
- `cache_index`  out  8; `cache_tag`  out  5; `cache_offset`  out  3; `cache_data_in`  out  16
- `mem_rd`, `mem_wr`  out  1 each; `mem_addr`  out  16; `mem_data_in`  out  16
- `xfer_busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, WB, FILL_ISSUE, FILL_DRAIN, DONE. 2-bit word counter `k`, 2-bit return counter `j`.
- IDLE: all outputs 0. On `start`: latch `miss_addr`, `victim_tag`, `evict`, `fill`; go WB if `evict`, else FILL_ISSUE if `fill`, else DONE.
- WB (word k): `cache_en`=1, `cache_wr`=0, `cache_offset`={k,0}, `mem_addr`={victim_tag,index,k,0}, `mem_data_in`=`cache_data_out`, `mem_wr`=~busy[k]. k advances only when busy[k]=0. After k=3 accepted: FILL_ISSUE if `fill`, else DONE.
- FILL_ISSUE (word k): `mem_rd`=~busy[k], `mem_addr`={tag,index,k,0}; issued words enter a MEM_LAT-deep return pipe (valid + word index). After k=3 issued: FILL_DRAIN.
- Return write (FILL_ISSUE or FILL_DRAIN, when pipe output valid): `cache_en`=1, `cache_wr`=1, `cache_valid_in`=1, `cache_tag`=latched tag, `cache_offset`={j,0}, `cache_data_in`=`mem_data_out`; j increments.
- FILL_DRAIN: wait until j wraps after word 3 written, then DONE.
- DONE: `done`=1 for one cycle, clear latches, go IDLE.
- `cache_index` = latched index in all non-IDLE states.
- `start` while `xfer_busy` is ignored (not queued).
- Counters wrap 3→0; a wrap is the exit condition, never an error.

## Timing
- Reset (rst=0 at clock edge): state IDLE, counters 0, return pipe cleared, all outputs 0. Reset mid-transfer abandons it; in-flight reads are discarded, no `done`.
- No stalls, start sampled at cycle 0: evict+fill WB cycles 1–4, issue 5–8, cache writes 7–10, `done` cycle 11. Fill-only: issue 1–4, writes 3–6, `done` 7. Evict-only: WB 1–4, `done` 5. Neither: `done` 1.
- Each busy cycle on the current bank adds exactly one cycle; a stall never drops or duplicates a word.
- `mem_rd` and `mem_wr` are never both 1; writeback and fill never overlap.

## Structure
- Shared package: TAG_W=5, IDX_W=8, WORDS=4, state encodings, MEM_LAT default.
- State and counters in `dff` instances; next-state/output logic in one combinational block.
- Sub-module `xfer_ret_pipe`: MEM_LAT-stage shift register of {valid, word[1:0]}, synchronous active-low clear.

## Test plan
- Fill-only, miss_addr=16'h1238, memory words 0xA0..0xA3, no busy -> cache writes offsets 0,2,4,6 with 0xA0..0xA3, tag=0x02, index=0x47, valid_in=1; `done` at cycle 7.
- Evict+fill, victim_tag=5'h1F, cache holds 0xB0..0xB3 -> mem writes 0xB0..0xB3 to 0xFA38..0xFA3E cycles 1–4, fill as above, `done` at cycle 11.
- busy[2]=1 for 3 cycles during FILL_ISSUE k=2 -> `mem_rd` low those cycles, all 4 words still written once, `done` 3 cycles late.
- `start` pulsed again mid-transfer -> ignored; exactly one `done`.
- rst=0 at cycle 6 of evict+fill -> next cycle all outputs 0, state IDLE, no `done`; a fresh request then completes normally.
- `start` with evict=fill=0 -> `done` at cycle 1, no cache or memory access.
